// File: rtl/qenc_pkg.sv
// Shared types and helpers for the quadrature encoder decoder.
// Phase encoding of the forward sequence and the step decode function.
package qenc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_t;

  // Forward sequence {A,B}: 00 -> 10 -> 11 -> 01, phase 0 in the low bits.
  localparam logic [7:0] QENC_FWD_SEQ = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] qenc_phase(input logic [1:0] s);
    logic [1:0] ph;
    ph = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (QENC_FWD_SEQ[2*i +: 2] == s) ph = 2'(i);
    end
    return ph;
  endfunction

  // Phase distance 1 is forward, 3 (i.e. -1) is reverse, 2 means both pins moved.
  function automatic step_t qenc_decode(input logic [1:0] prev, input logic [1:0] curr);
    logic [1:0] dp;
    dp = qenc_phase(curr) - qenc_phase(prev);
    case (dp)
      2'd0:    return STEP_NONE;
      2'd1:    return STEP_INC;
      2'd3:    return STEP_DEC;
      default: return STEP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/qenc_input_filter.sv
// Per-channel synchroniser with optional glitch filter (QENC_GLITCH_FILTER_EN).
// With the filter, the level register acts as the final synchroniser stage.
module qenc_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_param
    $error("qenc_input_filter: SYNC_STAGES and FILT_LEN must be >= 2");
  end

`ifdef QENC_GLITCH_FILTER_EN
  localparam int CHAIN = SYNC_STAGES - 1;
`else
  localparam int CHAIN = SYNC_STAGES;
`endif

  logic [CHAIN-1:0] sync_q, sync_d;
  logic             sync_out;

  always_comb begin
    sync_d = CHAIN'({sync_q, din});
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign sync_out = sync_q[CHAIN-1];

`ifdef QENC_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Level follows only after FILT_LEN consecutive differing samples.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) filt_d = sync_out;
      else                               cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_out;
`endif

endmodule

// File: rtl/quad_encoder_speed.sv
// x4 quadrature decoder: position counter, windowed saturating speed, sticky error.
// Optional input glitch filter enabled by QENC_GLITCH_FILTER_EN.
module quad_encoder_speed
  import qenc_pkg::*;
#(
  parameter int SPEED_W     = 16,
  parameter int POS_W       = 32,
  parameter int PERIOD      = 1250000,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inA,
  input  logic                      inB,
  input  logic                      clear_pos,
  input  logic                      clear_err,
  output logic signed [SPEED_W-1:0] speed,
  output logic                      speed_valid,
  output logic signed [POS_W-1:0]   position,
  output logic                      dir,
  output logic                      err
);

  if (PERIOD < 2) begin : g_bad_period
    $error("quad_encoder_speed: PERIOD must be >= 2");
  end

  localparam int CNT_W = $clog2(PERIOD);
  localparam logic signed [SPEED_W-1:0] SPEED_MAX = {1'b0, {(SPEED_W-1){1'b1}}};
  localparam logic signed [SPEED_W-1:0] SPEED_MIN = {1'b1, {(SPEED_W-1){1'b0}}};

  logic       a_f, b_f;
  logic [1:0] s;

  qenc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .din(inA), .dout(a_f)
  );

  qenc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .din(inB), .dout(b_f)
  );

  assign s = {a_f, b_f};

  logic [1:0]                prev_q, prev_d;
  logic                      primed_q, primed_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic signed [SPEED_W-1:0] acc_q, acc_d;
  logic signed [SPEED_W-1:0] speed_q, speed_d;
  logic                      valid_q, valid_d;
  logic                      dir_q, dir_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  step_t                     step;
  logic signed [1:0]         delta;
  logic signed [SPEED_W:0]   acc_sum;
  logic signed [SPEED_W-1:0] acc_sat;

  always_comb begin
    // Until primed, prev holds no real sample, so nothing is counted.
    step     = primed_q ? qenc_decode(prev_q, s) : STEP_NONE;
    delta    = 2'sd0;
    dir_d    = dir_q;
    err_d    = err_q;
    prev_d   = s;
    primed_d = 1'b1;

    case (step)
      STEP_INC: begin delta = 2'sd1;  dir_d = 1'b1; end
      STEP_DEC: begin delta = -2'sd1; dir_d = 1'b0; end
      default:  ;
    endcase

    if (step == STEP_ERR) err_d = 1'b1;
    else if (clear_err)   err_d = 1'b0;

    pos_d = clear_pos ? '0 : pos_q + {{(POS_W-2){delta[1]}}, delta};

    // One guard bit detects overflow; clamp instead of wrapping.
    acc_sum = {acc_q[SPEED_W-1], acc_q} + {{(SPEED_W-1){delta[1]}}, delta};
    if (acc_sum[SPEED_W] != acc_sum[SPEED_W-1])
      acc_sat = acc_sum[SPEED_W] ? SPEED_MIN : SPEED_MAX;
    else
      acc_sat = acc_sum[SPEED_W-1:0];

    speed_d = speed_q;
    valid_d = 1'b0;
    acc_d   = acc_sat;
    cnt_d   = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_W'(PERIOD - 1)) begin
      speed_d = acc_sat;
      valid_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      pos_q    <= '0;
      acc_q    <= '0;
      speed_q  <= '0;
      valid_q  <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      acc_q    <= acc_d;
      speed_q  <= speed_d;
      valid_q  <= valid_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign speed       = speed_q;
  assign speed_valid = valid_q;
  assign position    = pos_q;
  assign dir         = dir_q;
  assign err         = err_q;

endmodule

// File: tb/tb_quad_encoder_speed.sv
// Directed bench for quad_encoder_speed: a 16-bit speed instance and a 4-bit
// saturating-speed instance share the same encoder stimulus.
module tb_quad_encoder_speed;

  localparam int PERIOD      = 100;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
`ifdef QENC_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + FILT_LEN;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic        clk = 1'b0;
  logic        reset, inA, inB, clear_pos, clear_err;
  logic [15:0] speed;
  logic        speed_valid;
  logic [31:0] position;
  logic        dir, err;
  logic [3:0]  speed_s;
  logic        valid_s;
  logic [31:0] pos_s;
  logic        dir_s, err_s;

  int n_cmp = 0;
  int n_bad = 0;
  int ph    = 0;
  int n     = 0;
  logic [1:0] seq [4];

  always #5 clk = ~clk;

  quad_encoder_speed #(
    .SPEED_W(16), .POS_W(32), .PERIOD(PERIOD), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk), .reset(reset), .inA(inA), .inB(inB), .clear_pos(clear_pos), .clear_err(clear_err),
    .speed(speed), .speed_valid(speed_valid), .position(position), .dir(dir), .err(err)
  );

  quad_encoder_speed #(
    .SPEED_W(4), .POS_W(32), .PERIOD(PERIOD), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
  ) dut_s (
    .clk(clk), .reset(reset), .inA(inA), .inB(inB), .clear_pos(clear_pos), .clear_err(clear_err),
    .speed(speed_s), .speed_valid(valid_s), .position(pos_s), .dir(dir_s), .err(err_s)
  );

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step the pins d phases along the forward sequence, then hold for gap cycles.
  task automatic move(input int d, input int gap);
    ph = (ph + d + 4) % 4;
    {inA, inB} = seq[ph];
    tick(gap);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (speed_valid !== 1'b1 && cycles < 3 * PERIOD);
  endtask

  task automatic check_window(input string tag, input logic [15:0] e16, input logic [3:0] e4);
    wait_valid(n);
    chk({tag, "_valid"}, 64'(speed_valid), 64'd1);
    chk({tag, "_speed"}, 64'(speed), 64'(e16));
    chk({tag, "_speed4"}, 64'(speed_s), 64'(e4));
  endtask

  initial begin
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    reset = 1'b1; inA = 1'b0; inB = 1'b0; clear_pos = 1'b0; clear_err = 1'b0;
    tick(3);
    chk("rst_speed", 64'(speed), 64'd0);
    chk("rst_valid", 64'(speed_valid), 64'd0);
    chk("rst_pos", 64'(position), 64'd0);
    chk("rst_dir", 64'(dir), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // First strobe exactly PERIOD cycles after release, empty window.
    reset = 1'b0;
    wait_valid(n);
    chk("first_valid_latency", 64'(n), 64'(PERIOD));
    chk("first_speed", 64'(speed), 64'd0);

    // Ten forward steps inside one window.
    for (int i = 0; i < 10; i++) move(1, 8);
    chk("fwd_pos", 64'(position), 64'd10);
    chk("fwd_dir", 64'(dir), 64'd1);
    check_window("fwd_win", 16'd10, 4'h7);
    tick(1);
    chk("valid_one_cycle", 64'(speed_valid), 64'd0);
    check_window("empty_win", 16'd0, 4'h0);

    // clear_pos coincident with a +1 step: position zero, speed keeps the step.
    ph = (ph + 1) % 4;
    {inA, inB} = seq[ph];
    tick(LAT - 1);
    clear_pos = 1'b1;
    tick(1);
    clear_pos = 1'b0;
    chk("clrpos_pos", 64'(position), 64'd0);
    tick(4);
    chk("clrpos_pos_hold", 64'(position), 64'd0);
    check_window("clrpos_win", 16'd1, 4'h1);

    // Five reverse steps from zero.
    for (int i = 0; i < 5; i++) move(-1, 8);
    chk("rev_pos", 64'(position), 64'hFFFF_FFFB);
    chk("rev_dir", 64'(dir), 64'd0);
    check_window("rev_win", 16'hFFFB, 4'hB);

    // Illegal jump 11 -> 00, then clear, then illegal coincident with clear_err.
    move(2, LAT);
    chk("illegal_err", 64'(err), 64'd1);
    chk("illegal_pos", 64'(position), 64'hFFFF_FFFB);
    chk("illegal_dir", 64'(dir), 64'd0);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("clear_err", 64'(err), 64'd0);
    ph = (ph + 2) % 4;
    {inA, inB} = seq[ph];
    tick(LAT - 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("set_wins_err", 64'(err), 64'd1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("clear_err2", 64'(err), 64'd0);
    check_window("illegal_win", 16'd0, 4'h0);

    // Saturation of the 4-bit speed in both directions.
    clear_pos = 1'b1;
    tick(1);
    clear_pos = 1'b0;
    chk("sat_clrpos", 64'(position), 64'd0);
    for (int i = 0; i < 12; i++) move(1, 7);
    chk("sat_pos", 64'(position), 64'd12);
    check_window("sat_pos_win", 16'd12, 4'h7);
    for (int i = 0; i < 12; i++) move(-1, 7);
    chk("sat_neg_pos", 64'(position), 64'd0);
    check_window("sat_neg_win", 16'hFFF4, 4'h8);

    // Reset mid-window with partial accumulation (pins back at 00 first).
    tick(20);
    move(1, 8);
    move(1, 8);
    chk("pre_rst_pos", 64'(position), 64'd2);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_speed", 64'(speed), 64'd0);
    chk("mid_rst_speed4", 64'(speed_s), 64'd0);
    chk("mid_rst_valid", 64'(speed_valid), 64'd0);
    chk("mid_rst_pos", 64'(position), 64'd0);
    chk("mid_rst_dir", 64'(dir), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    reset = 1'b0;
    wait_valid(n);
    chk("rst_valid_latency", 64'(n), 64'(PERIOD));
    chk("rst_partial_discarded", 64'(speed), 64'd0);

`ifdef QENC_GLITCH_FILTER_EN
    // A 3-cycle pulse is rejected; a stable change yields one step.
    inA = 1'b1;
    tick(3);
    inA = 1'b0;
    tick(12);
    chk("glitch_pos", 64'(position), 64'd0);
    chk("glitch_err", 64'(err), 64'd0);
    inA = 1'b1;
    tick(12);
    chk("stable_pos", 64'(position), 64'd1);
    chk("stable_dir", 64'(dir), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder_speed.md
Name: quad_encoder_speed

Overview:
Parametrised single-clock quadrature decoder for the motor encoder channels A/B.
- Synchronises and optionally filters the asynchronous encoder inputs.
- Decodes x4 quadrature into signed steps: an absolute position counter plus a signed per-window speed with a valid strobe.
- Flags illegal transitions.
- Sits between the encoder pins and the odometry/motor-control logic. All logic is on `clk`; encoder edges are never used as clocks.

Parameters:
- SPEED_W, 16, width of signed speed output (ticks per window).
- POS_W, 32, width of signed position counter.
- PERIOD, 1250000, window length in clk cycles (25 ms at 50 MHz). Legal range is ≥ 2.
- SYNC_STAGES, 2, synchroniser flops per input. Legal range is ≥ 2.
- FILT_LEN, 4, stability length in cycles. Used only with QENC_GLITCH_FILTER_EN; legal range is ≥ 2.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- inA, in, 1, encoder channel A (asynchronous).
- inB, in, 1, encoder channel B (asynchronous).
- clear_pos, in, 1, zero position counter.
- clear_err, in, 1, clear sticky error flag.
- speed, out, SPEED_W, signed ticks counted in the last completed window.
- speed_valid, out, 1, one-cycle strobe when speed updates.
- position, out, POS_W, signed accumulated ticks.
- dir, out, 1, direction of last legal step (1 = forward).
- err, out, 1, sticky illegal-transition flag.

Behaviour:
- Reset: clk and reset as above (synchronous, active-high).
  - Every output is 0: speed, speed_valid, position, dir, err.
  - Also cleared: synchroniser/filter flops, window counter, accumulator, primed flag.
- Input path: each input passes SYNC_STAGES flops, then the optional filter, giving the sampled state s = {A,B}.
- Priming: the first cycle after reset loads prev = s, sets primed, and counts nothing. This prevents a spurious step when the pins are not at 00.
- Decode, once primed, compares prev against s every cycle, then sets prev <= s.
  - Forward sequence 00→10→11→01→00: step = +1, dir <= 1.
  - Reverse sequence: step = −1, dir <= 0.
  - No change: step = 0.
  - Both bits changed: illegal. step = 0, err <= 1, dir unchanged.
- Latency: a pin change reaches position SYNC_STAGES+1 cycles later without the filter; add FILT_LEN−1 cycles with the filter.
- position:
  - position <= position + step, wrapping modulo 2^POS_W.
  - clear_pos has priority: position <= 0 and that cycle's step is discarded from position only. The step still enters the speed accumulator.
- Window:
  - Counter runs 0..PERIOD−1.
  - At count PERIOD−1: speed <= sat(acc + step), acc <= 0, speed_valid <= 1 for exactly one cycle, counter <= 0.
  - Otherwise: acc <= sat(acc + step).
  - sat() saturates to the signed SPEED_W range [−2^(SPEED_W−1), 2^(SPEED_W−1)−1]. It never wraps.
- err: set and clear_err in the same cycle leaves err = 1 (set wins). Otherwise clear_err clears err.
- Reset mid-window discards the partial accumulation. The first speed_valid after reset release comes PERIOD cycles later.

Optional Feature:
- Macro: QENC_GLITCH_FILTER_EN.
- Defined: per input, a FILT_LEN-cycle stability counter follows the synchroniser. The filtered level updates only after the synchronised level has differed from it for FILT_LEN consecutive cycles. Shorter pulses are ignored entirely.
- Undefined: filtered level = synchronised level, with no added latency.

Decomposition:
- Package qenc_pkg holds:
  - typedef enum logic [1:0] step_t {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR};
  - function qenc_decode(prev, curr) returning step_t;
  - localparam for forward-sequence encoding.
- Sub-module qenc_input_filter holds the synchroniser plus the optional filter. It is instantiated once per channel.

Test Plan:
- PERIOD=100, 10 forward steps spaced 8 cycles within one window -> position=10, dir=1, next speed_valid gives speed=10; the following empty window gives speed=0.
- Reverse 5 steps from position 0 -> position=−5 (all ones in POS_W), dir=0, speed=−5.
- Jump {A,B} 00→11 -> err=1, position unchanged; clear_err the next cycle -> err=0; illegal transition coincident with clear_err -> err stays 1.
- SPEED_W=4, 12 forward steps in one window -> speed=7 (saturated); position=12.
- clear_pos asserted in the same cycle as a +1 step -> position=0 and the window speed still includes that step; reset asserted mid-window -> all outputs 0 and no speed_valid for PERIOD cycles.
- With QENC_GLITCH_FILTER_EN and FILT_LEN=4: a 3-cycle A pulse -> no step; a 4-cycle stable change -> exactly one step.
